// File: rtl/mem_wb_stage.sv
// MIPS memory-access stage with the MEM/WB pipeline register.
// Word-addressed data memory, async read, alignment check with sticky error capture.
module mem_wb_stage #(
    parameter int ADDR_BITS = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  WB,
    input  logic [1:0]  M,
    input  logic [31:0] ALUOut,
    input  logic [31:0] WriteDataIn,
    input  logic [4:0]  RegRD,
    input  logic        stall,
    input  logic        flush,
    output logic [1:0]  WBreg,
    output logic [31:0] ReadDataReg,
    output logic [31:0] ALUreg,
    output logic [4:0]  RegRDreg,
    output logic [31:0] WriteBackData,
    output logic        RegWriteOut,
    output logic        align_err,
    output logic [31:0] err_addr
);
    localparam int DEPTH = 1 << ADDR_BITS;

    logic [31:0]          mem_q [DEPTH];
    logic [ADDR_BITS-1:0] word_idx;
    logic                 misaligned;
    logic                 store_en;
    logic [31:0]          rd_data;

    logic [1:0]  wbreg_q, wbreg_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] alureg_q, alureg_d;
    logic [4:0]  rdreg_q, rdreg_d;
    logic        aerr_q, aerr_d;
    logic [31:0] eaddr_q, eaddr_d;

    always_comb begin
        word_idx   = ALUOut[ADDR_BITS+1:2];
        misaligned = (ALUOut[1:0] != 2'b00) && (M[1] | M[0]);
        // Stores are also blocked while reset is held so a reset edge never commits one.
        store_en   = M[0] && !misaligned && !stall && !flush && !reset;
        // Read happens before the same-edge store lands, giving old data for M=2'b11.
        rd_data    = (M[1] && !misaligned) ? mem_q[word_idx] : 32'h0;

        wbreg_d  = wbreg_q;
        rdata_d  = rdata_q;
        alureg_d = alureg_q;
        rdreg_d  = rdreg_q;
        if (flush) begin
            wbreg_d  = 2'b00;
            rdata_d  = 32'h0;
            alureg_d = 32'h0;
            rdreg_d  = 5'd0;
        end else if (!stall) begin
            wbreg_d  = {WB[1] & ~misaligned, WB[0]};
            rdata_d  = rd_data;
            alureg_d = ALUOut;
            rdreg_d  = RegRD;
        end

        aerr_d  = aerr_q;
        eaddr_d = eaddr_q;
        if (misaligned && !stall && !flush) begin
            aerr_d = 1'b1;
            if (!aerr_q) eaddr_d = ALUOut;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wbreg_q  <= 2'b00;
            rdata_q  <= 32'h0;
            alureg_q <= 32'h0;
            rdreg_q  <= 5'd0;
            aerr_q   <= 1'b0;
            eaddr_q  <= 32'h0;
        end else begin
            wbreg_q  <= wbreg_d;
            rdata_q  <= rdata_d;
            alureg_q <= alureg_d;
            rdreg_q  <= rdreg_d;
            aerr_q   <= aerr_d;
            eaddr_q  <= eaddr_d;
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clock) begin
        if (store_en) mem_q[word_idx] <= WriteDataIn;
    end

    assign WBreg         = wbreg_q;
    assign ReadDataReg   = rdata_q;
    assign ALUreg        = alureg_q;
    assign RegRDreg      = rdreg_q;
    assign align_err     = aerr_q;
    assign err_addr      = eaddr_q;
    assign WriteBackData = wbreg_q[0] ? rdata_q : alureg_q;
    assign RegWriteOut   = wbreg_q[1] & (rdreg_q != 5'd0);
endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed vector table, stall/reset sequences,
// then random traffic against an array-based memory model.
module tb_mem_wb_stage;
    logic        clk = 0;
    logic        reset;
    logic [1:0]  wb_i, m_i;
    logic [31:0] alu_i, wd_i;
    logic [4:0]  rd_i;
    logic        stall_i, flush_i;
    logic [1:0]  WBreg;
    logic [31:0] ReadDataReg, ALUreg, WriteBackData, err_addr;
    logic [4:0]  RegRDreg;
    logic        RegWriteOut, align_err;

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [31:0] mmem [256];
    logic [1:0]  e_wb;
    logic [31:0] e_rdd, e_alu, e_eaddr;
    logic [4:0]  e_rd;
    logic        e_aerr;

    typedef struct {
        logic [1:0]  wb, m;
        logic [31:0] alu, wd;
        logic [4:0]  rd;
        logic        st, fl;
        logic [1:0]  x_wb;
        logic [31:0] x_wbd;
        logic        x_rwo, x_aerr;
        logic [31:0] x_eaddr;
    } vec_t;
    vec_t vt[14];

    always #5 clk = ~clk;

    mem_wb_stage #(.ADDR_BITS(8)) dut (
        .clock(clk), .reset(reset), .WB(wb_i), .M(m_i), .ALUOut(alu_i),
        .WriteDataIn(wd_i), .RegRD(rd_i), .stall(stall_i), .flush(flush_i),
        .WBreg(WBreg), .ReadDataReg(ReadDataReg), .ALUreg(ALUreg),
        .RegRDreg(RegRDreg), .WriteBackData(WriteBackData),
        .RegWriteOut(RegWriteOut), .align_err(align_err), .err_addr(err_addr)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h req=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".WBreg"}, 32'(WBreg), 32'(e_wb));
        chk({tag, ".ReadDataReg"}, ReadDataReg, e_rdd);
        chk({tag, ".ALUreg"}, ALUreg, e_alu);
        chk({tag, ".RegRDreg"}, 32'(RegRDreg), 32'(e_rd));
        chk({tag, ".WBData"}, WriteBackData, e_wb[0] ? e_rdd : e_alu);
        chk({tag, ".RegWriteOut"}, 32'(RegWriteOut), 32'(e_wb[1] && e_rd != 0));
        chk({tag, ".align_err"}, 32'(align_err), 32'(e_aerr));
        chk({tag, ".err_addr"}, err_addr, e_eaddr);
    endtask

    task automatic model_reset();
        e_wb = 0; e_rdd = 0; e_alu = 0; e_rd = 0; e_aerr = 0; e_eaddr = 0;
    endtask

    // Spec rules applied to the currently driven inputs for one rising edge.
    task automatic model_edge();
        bit          mis;
        int unsigned idx;
        logic [31:0] rd;
        mis = (alu_i % 4 != 0) && (m_i != 0);
        idx = (alu_i / 4) % 256;
        rd  = (m_i[1] && !mis) ? mmem[idx] : 32'h0;
        if (!stall_i && !flush_i) begin
            if (mis) begin
                if (!e_aerr) e_eaddr = alu_i;
                e_aerr = 1;
            end
            if (m_i[0] && !mis) mmem[idx] = wd_i;
        end
        if (flush_i) begin
            e_wb = 0; e_rdd = 0; e_alu = 0; e_rd = 0;
        end else if (!stall_i) begin
            e_wb  = mis ? {1'b0, wb_i[0]} : wb_i;
            e_rdd = rd;
            e_alu = alu_i;
            e_rd  = rd_i;
        end
    endtask

    task automatic setin(input logic [1:0] wb, input logic [1:0] m, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [4:0] rd, input logic st, input logic fl);
        wb_i = wb; m_i = m; alu_i = alu; wd_i = wd; rd_i = rd; stall_i = st; flush_i = fl;
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    function automatic vec_t mkv(input logic [1:0] wb, input logic [1:0] m, input logic [31:0] alu,
                                 input logic [31:0] wd, input logic [4:0] rd, input logic st,
                                 input logic fl, input logic [1:0] x_wb, input logic [31:0] x_wbd,
                                 input logic x_rwo, input logic x_aerr, input logic [31:0] x_eaddr);
        vec_t v;
        v.wb = wb; v.m = m; v.alu = alu; v.wd = wd; v.rd = rd; v.st = st; v.fl = fl;
        v.x_wb = x_wb; v.x_wbd = x_wbd; v.x_rwo = x_rwo; v.x_aerr = x_aerr; v.x_eaddr = x_eaddr;
        return v;
    endfunction

    initial begin
        vt[0]  = mkv(2'b00, 2'b01, 32'h14,  32'hDEADBEEF, 0, 0, 0, 2'b00, 32'h14,       0, 0, 0);
        vt[1]  = mkv(2'b11, 2'b10, 32'h14,  32'h0,        9, 0, 0, 2'b11, 32'hDEADBEEF, 1, 0, 0);
        vt[2]  = mkv(2'b10, 2'b00, 32'h1234, 32'h0,       3, 0, 0, 2'b10, 32'h1234,     1, 0, 0);
        vt[3]  = mkv(2'b10, 2'b00, 32'h7,   32'h0,        0, 0, 0, 2'b10, 32'h7,        0, 0, 0);
        vt[4]  = mkv(2'b00, 2'b01, 32'h400, 32'h55,       0, 0, 0, 2'b00, 32'h400,      0, 0, 0);
        vt[5]  = mkv(2'b11, 2'b10, 32'h0,   32'h0,        4, 0, 0, 2'b11, 32'h55,       1, 0, 0);
        vt[6]  = mkv(2'b10, 2'b01, 32'h16,  32'h99,       2, 0, 0, 2'b00, 32'h16,       0, 1, 32'h16);
        vt[7]  = mkv(2'b11, 2'b10, 32'h14,  32'h0,        5, 0, 0, 2'b11, 32'hDEADBEEF, 1, 1, 32'h16);
        vt[8]  = mkv(2'b11, 2'b10, 32'h21,  32'h0,        6, 0, 0, 2'b01, 32'h0,        0, 1, 32'h16);
        vt[9]  = mkv(2'b00, 2'b01, 32'h30,  32'h1,        0, 0, 0, 2'b00, 32'h30,       0, 1, 32'h16);
        vt[10] = mkv(2'b01, 2'b11, 32'h30,  32'h2,        7, 0, 0, 2'b01, 32'h1,        0, 1, 32'h16);
        vt[11] = mkv(2'b01, 2'b10, 32'h30,  32'h0,        7, 0, 0, 2'b01, 32'h2,        0, 1, 32'h16);
        vt[12] = mkv(2'b11, 2'b01, 32'h30,  32'h9,        8, 1, 1, 2'b00, 32'h0,        0, 1, 32'h16);
        vt[13] = mkv(2'b01, 2'b10, 32'h30,  32'h0,        1, 0, 0, 2'b01, 32'h2,        0, 1, 32'h16);

        reset = 1;
        setin(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #3;
        check_all("reset0");
        @(posedge clk); #1;
        reset = 0;

        // Give every word a known value.
        for (int i = 0; i < 256; i++) begin
            setin(2'b00, 2'b01, 32'(i * 4), $urandom, 0, 0, 0);
            step("preload");
        end

        // Asynchronous reset between edges; memory must survive.
        setin(2'b11, 2'b10, 32'h40, 0, 3, 0, 0);
        #2 reset = 1;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk); #1;
        check_all("rst_hold");
        reset = 0;
        setin(2'b01, 2'b10, 32'h14, 0, 1, 0, 0);
        step("word5_kept");

        for (int i = 0; i < 14; i++) begin
            setin(vt[i].wb, vt[i].m, vt[i].alu, vt[i].wd, vt[i].rd, vt[i].st, vt[i].fl);
            step($sformatf("vec%0d", i));
            chk($sformatf("vec%0d.WBreg", i), 32'(WBreg), 32'(vt[i].x_wb));
            chk($sformatf("vec%0d.WBData", i), WriteBackData, vt[i].x_wbd);
            chk($sformatf("vec%0d.RegWriteOut", i), 32'(RegWriteOut), 32'(vt[i].x_rwo));
            chk($sformatf("vec%0d.align_err", i), 32'(align_err), 32'(vt[i].x_aerr));
            chk($sformatf("vec%0d.err_addr", i), err_addr, vt[i].x_eaddr);
        end

        // Stalled store: held three edges, then fires once.
        setin(2'b10, 2'b01, 32'h8, 32'hA5A5A5A5, 12, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step("stall_hold");
            chk("stall_hold.ALUreg", ALUreg, 32'h30);
        end
        stall_i = 0;
        step("stall_release");
        chk("stall_release.ALUreg", ALUreg, 32'h8);
        setin(2'b01, 2'b10, 32'h8, 0, 12, 0, 0);
        step("stall_load");
        chk("stall_load.data", WriteBackData, 32'hA5A5A5A5);

        // Reset mid-stall; a store presented on the reset edge is dropped.
        setin(2'b10, 2'b01, 32'h8, 32'h11, 13, 1, 0);
        step("pre_rst_stall");
        #2 reset = 1;
        #1;
        model_reset();
        check_all("rst_in_stall");
        setin(2'b10, 2'b01, 32'h8, 32'h22, 13, 0, 0);
        @(posedge clk); #1;
        check_all("rst_edge_store");
        reset = 0;
        setin(2'b01, 2'b10, 32'h8, 0, 14, 0, 0);
        step("post_rst_load");
        chk("post_rst_load.data", WriteBackData, 32'hA5A5A5A5);

        // Random traffic, mostly aligned, with occasional stall/flush.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 9) != 0) a[1:0] = 2'b00;
            setin(2'($urandom), 2'($urandom), a, $urandom, 5'($urandom),
                  $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0);
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
